fwd_hazard_ctrl: RTL and testbench
==================================

// Module: fwd_hazard_ctrl
// PURPOSE
//  Forwarding and hazard controller for the EX stage. Tracks destination registers of
//  instructions in EX, MEM and WB, and produces the registered operand selects
//  alu_1_sel, alu_2_sel and st_data_sel. Detects load-use hazards, stalls IF/ID and
//  inserts one EX bubble. Sits beside the ID/EX pipeline register and is fed by the decoder.
// PARAMETERS
//  RA_W   5   register address width; register 0 is hardwired zero
//  CNT_W  32  width of the load-use stall event counter
// PORTS
//  clk            in   1      clock
//  rst            in   1      synchronous reset, active-low
//  hold           in   1      global freeze; all internal state and outputs hold
//  id_valid       in   1      ID holds a real instruction
//  id_rs          in   RA_W   ALU operand 1 source register
//  id_rt          in   RA_W   ALU operand 2 / store data source register
//  id_use_rs      in   1      operand 1 reads id_rs
//  id_use_rt_alu  in   1      operand 2 reads id_rt (0 = immediate)
//  id_is_store    in   1      store; store data comes from id_rt
//  id_dest        in   RA_W   destination register
//  id_wb_en       in   1      instruction writes id_dest
//  id_mem_r       in   1      instruction is a load
//  stall          out  1      combinational; IF/ID must hold this cycle
//  alu_1_sel      out  2      registered; 00 ID/EX data, 01 MEM, 10 WB
//  alu_2_sel      out  2      registered; same encoding
//  st_data_sel    out  2      registered; same encoding
//  stall_count    out  CNT_W  registered; number of load-use stall cycles, saturating
// BEHAVIOUR
//  - Reset (rst==0 at posedge): all sel outputs 2'b00, stall_count 0. Every tracked stage
//    is invalid: ex/mem/wb wb_en=0, mem_r=0, dest=0. Reset overrides hold.
//  - Tracking regs: ex_{dest,wb_en,mem_r}, mem_{dest,wb_en}, wb_{dest,wb_en}. They
//    advance every cycle with hold==0: wb<=mem, mem<=ex, ex<=ID or a bubble.
//  - A stage "writes r" iff its wb_en==1 and dest==r and r!=0.
//  - Select calc (for the ID instr, using pre-edge state): a source is used when its use
//    flag is set and id_valid=1. If ex writes src, sel=01: that instr will be in MEM.
//    Else if mem writes src, sel=10: it will be in WB. Else sel=00.
//    MEM has priority over WB. st_data_sel uses id_rt and id_is_store.
//  - Load-use: load_use = id_valid & ex_mem_r & ex_wb_en & ex_dest!=0 & ex_dest
//    matches a used source (rs, rt-alu, or rt-store).
//    stall = load_use & ~hold.
//  - On a load_use edge (hold=0): ex <= bubble (wb_en=0, mem_r=0), all sels <= 00.
//    mem/wb still advance, and stall_count += 1, saturating at all-ones. Next cycle the
//    load is in mem_*, so stall drops and the dependent instr gets sel=10.
//  - If id_valid=0, ex <= bubble and sels <= 00.
//  - hold=1: no register changes, stall=0, outputs keep their values. Hold and hazard in
//    the same cycle: hold wins; the hazard is re-evaluated once hold falls.
//  - Sels update on the same edge that loads the instr into ID/EX (latency 1). They stay
//    valid for the whole EX cycle.
//  - Back-to-back loads to the same register: each load_use causes exactly one bubble.
//  - Reset mid-stall: all pipeline state is cleared; stall=0 on the next cycle unless
//    ex_mem_r is set again.
// STRUCTURE
//  - Shared constants package: SEL_IDEX=2'b00, SEL_MEM=2'b01, SEL_WB=2'b10, RA_W.
//    The EX-stage 3-input data muxes use the same package.
//  - One sub-module, fwd_sel_calc: combinational, per source. Inputs: src, use,
//    ex/mem dest+wb_en. Output: a 2-bit sel. Instantiated three times.
//  - Tracking regs, load-use detect and counter are in the top level.
// TESTING
//  1. Reset: drive rst=0 with random inputs for 2 cycles -> all sels 00, stall=0,
//     stall_count=0.
//  2. ALU RAW: add r3 then add r4,r3,r3 back-to-back -> second instr's alu_1_sel=01 and
//     alu_2_sel=01; with one unrelated instr between them -> both sels=10.
//  3. Load-use: lw r5 then sw r5 -> stall=1 for one cycle, bubble has sels=00,
//     stall_count=1. Next cycle stall=0 and st_data_sel=10.
//  4. r0 and immediate: add r0 then use r0 -> sels 00. Immediate op whose rt matches ex_dest
//     with id_use_rt_alu=0 -> alu_2_sel=00.
//  5. Priority: ex and mem both write r7, ID reads r7 -> sel=01. Hold raised for 3 cycles
//     during a load-use -> stall=0 and no state change; after release the stall fires once.
//  6. Saturation: preload stall_count near all-ones (CNT_W=4), create 20 load-use stalls
//     -> count stays 4'hF.

Source files
------------

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared constants for the EX-stage forwarding path.
// The select encoding is also used by the EX-stage 3-input operand muxes:
//   SEL_IDEX - operand comes from the ID/EX pipeline register
//   SEL_MEM  - operand comes from the result held in EX/MEM
//   SEL_WB   - operand comes from the result held in MEM/WB
package fwd_hazard_ctrl_pkg;

    localparam int RA_W = 5;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t SEL_IDEX = 2'b00;
    localparam fwd_sel_t SEL_MEM  = 2'b01;
    localparam fwd_sel_t SEL_WB   = 2'b10;

endpackage

// File: rtl/fwd_sel_calc.sv
// Forwarding select for one source operand of the instruction in ID.
// Ports:
//   src        source register read by the operand
//   use_src    operand really reads src (use flag already qualified by id_valid)
//   ex_dest    destination of the instruction now in EX
//   ex_wb_en   instruction now in EX writes ex_dest
//   mem_dest   destination of the instruction now in MEM
//   mem_wb_en  instruction now in MEM writes mem_dest
//   sel        operand select to apply once the ID instruction reaches EX
module fwd_sel_calc #(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] src,
    input  logic            use_src,
    input  logic [RA_W-1:0] ex_dest,
    input  logic            ex_wb_en,
    input  logic [RA_W-1:0] mem_dest,
    input  logic            mem_wb_en,
    output logic [1:0]      sel
);
    import fwd_hazard_ctrl_pkg::*;

    logic src_live;
    logic ex_hit;
    logic mem_hit;

    // Register 0 is hardwired zero, so a write to it never needs forwarding.
    assign src_live = use_src && (src != '0);
    assign ex_hit   = src_live && ex_wb_en  && (ex_dest  == src);
    assign mem_hit  = src_live && mem_wb_en && (mem_dest == src);

    // The EX producer is the younger one; it will sit in MEM when the consumer
    // executes, so it wins over the older MEM producer (which will be in WB).
    always_comb begin
        sel = SEL_IDEX;
        if (ex_hit) begin
            sel = SEL_MEM;
        end else if (mem_hit) begin
            sel = SEL_WB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the EX stage.
// Tracks the destinations of the instructions in EX and MEM, registers the
// operand selects for the instruction moving into EX, and stalls IF/ID for one
// cycle (inserting an EX bubble) when an instruction needs a load result that
// is still in EX.
// Ports:
//   clk, rst            clock; synchronous active-low reset (overrides hold)
//   hold                global freeze of all state and registered outputs
//   id_*                decoded fields of the instruction in ID
//   stall               combinational IF/ID hold request
//   alu_1_sel/alu_2_sel registered ALU operand selects for the instruction in EX
//   st_data_sel         registered store-data select for the instruction in EX
//   stall_count         saturating count of load-use stall cycles
module fwd_hazard_ctrl #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt_alu,
    input  logic             id_is_store,
    input  logic [RA_W-1:0]  id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_r,
    output logic             stall,
    output logic [1:0]       alu_1_sel,
    output logic [1:0]       alu_2_sel,
    output logic [1:0]       st_data_sel,
    output logic [CNT_W-1:0] stall_count
);
    import fwd_hazard_ctrl_pkg::*;

    // The instruction in WB has written the register file before the ID
    // instruction reaches EX, so only the EX and MEM tags affect selection.
    logic [RA_W-1:0] ex_dest;
    logic            ex_wb_en;
    logic            ex_mem_r;
    logic [RA_W-1:0] mem_dest;
    logic            mem_wb_en;

    logic       use_rs;
    logic       use_rt_alu;
    logic       use_rt_st;
    logic [1:0] sel_1_nxt;
    logic [1:0] sel_2_nxt;
    logic [1:0] sel_st_nxt;
    logic       ex_load_live;
    logic       load_use;
    logic       bubble;

    assign use_rs     = id_valid && id_use_rs;
    assign use_rt_alu = id_valid && id_use_rt_alu;
    assign use_rt_st  = id_valid && id_is_store;

    fwd_sel_calc #(.RA_W(RA_W)) u_sel_1 (
        .src(id_rs), .use_src(use_rs),
        .ex_dest(ex_dest), .ex_wb_en(ex_wb_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .sel(sel_1_nxt)
    );

    fwd_sel_calc #(.RA_W(RA_W)) u_sel_2 (
        .src(id_rt), .use_src(use_rt_alu),
        .ex_dest(ex_dest), .ex_wb_en(ex_wb_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .sel(sel_2_nxt)
    );

    fwd_sel_calc #(.RA_W(RA_W)) u_sel_st (
        .src(id_rt), .use_src(use_rt_st),
        .ex_dest(ex_dest), .ex_wb_en(ex_wb_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .sel(sel_st_nxt)
    );

    // A load in EX has no data until it leaves MEM, so any consumer in ID
    // must wait one cycle and then pick the value up from WB.
    assign ex_load_live = ex_mem_r && ex_wb_en && (ex_dest != '0);
    assign load_use = id_valid && ex_load_live &&
                      ((use_rs     && (id_rs == ex_dest)) ||
                       (use_rt_alu && (id_rt == ex_dest)) ||
                       (use_rt_st  && (id_rt == ex_dest)));
    assign stall  = load_use && !hold;
    assign bubble = load_use || !id_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_dest     <= '0;
            ex_wb_en    <= 1'b0;
            ex_mem_r    <= 1'b0;
            mem_dest    <= '0;
            mem_wb_en   <= 1'b0;
            alu_1_sel   <= SEL_IDEX;
            alu_2_sel   <= SEL_IDEX;
            st_data_sel <= SEL_IDEX;
            stall_count <= '0;
        end else if (!hold) begin
            mem_dest  <= ex_dest;
            mem_wb_en <= ex_wb_en;
            if (bubble) begin
                ex_dest     <= '0;
                ex_wb_en    <= 1'b0;
                ex_mem_r    <= 1'b0;
                alu_1_sel   <= SEL_IDEX;
                alu_2_sel   <= SEL_IDEX;
                st_data_sel <= SEL_IDEX;
            end else begin
                ex_dest     <= id_dest;
                ex_wb_en    <= id_wb_en;
                ex_mem_r    <= id_mem_r;
                alu_1_sel   <= sel_1_nxt;
                alu_2_sel   <= sel_2_nxt;
                st_data_sel <= sel_st_nxt;
            end
            if (load_use && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
module tb_fwd_hazard_ctrl;

    typedef struct packed {
        logic [1:0] a1;
        logic [1:0] a2;
        logic [1:0] sd;
        logic [3:0] cnt;
    } outs_t;

    logic       clk;
    logic       rst;
    logic       hold;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt_alu;
    logic       id_is_store;
    logic [4:0] id_dest;
    logic       id_wb_en;
    logic       id_mem_r;
    logic       stall;
    logic [1:0] alu_1_sel;
    logic [1:0] alu_2_sel;
    logic [1:0] st_data_sel;
    logic [3:0] stall_count;

    int    checks   = 0;
    int    failures = 0;
    logic [3:0] exp_cnt = 4'd0;
    outs_t exp_q[$];
    outs_t obs_q[$];
    string tag_q[$];

    fwd_hazard_ctrl #(.RA_W(5), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt_alu(id_use_rt_alu),
        .id_is_store(id_is_store), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_r(id_mem_r),
        .stall(stall), .alu_1_sel(alu_1_sel), .alu_2_sel(alu_2_sel),
        .st_data_sel(st_data_sel), .stall_count(stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic st,
                          input logic [4:0] dest, input logic wb, input logic mr);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs;
        id_use_rt_alu = urt; id_is_store = st; id_dest = dest;
        id_wb_en = wb; id_mem_r = mr;
    endtask

    task automatic nop_id();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic bump();
        if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
    endtask

    // Push the expected registered outputs, clock once, record what the DUT shows.
    task automatic cycle(input string tag, input logic [1:0] a1, input logic [1:0] a2,
                         input logic [1:0] sd);
        outs_t e;
        outs_t o;
        e.a1 = a1; e.a2 = a2; e.sd = sd; e.cnt = exp_cnt;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        o.a1 = alu_1_sel; o.a2 = alu_2_sel; o.sd = st_data_sel; o.cnt = stall_count;
        obs_q.push_back(o);
    endtask

    task automatic flush();
        nop_id();
        cycle("flush0", 2'b00, 2'b00, 2'b00);
        cycle("flush1", 2'b00, 2'b00, 2'b00);
    endtask

    task automatic test_reset();
        outs_t e, o; string t;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            hold = 1'($urandom);
            set_id(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
            cycle("reset", 2'b00, 2'b00, 2'b00);
            #1;
            checks++;
            if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b expected=0", stall); end
        end
        rst = 1'b1; hold = 1'b0;
        nop_id();
        cycle("reset_idle", 2'b00, 2'b00, 2'b00);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL %s got a1=%0d a2=%0d sd=%0d cnt=%0d expected a1=%0d a2=%0d sd=%0d cnt=%0d", t, o.a1, o.a2, o.sd, o.cnt, e.a1, e.a2, e.sd, e.cnt); end
        end
    endtask

    task automatic test_alu_raw();
        outs_t e, o; string t;
        flush();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
        cycle("raw_add_r3", 2'b00, 2'b00, 2'b00);
        set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
        cycle("raw_b2b", 2'b01, 2'b01, 2'b00);
        flush();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
        cycle("raw_add_r3b", 2'b00, 2'b00, 2'b00);
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
        cycle("raw_unrelated", 2'b00, 2'b00, 2'b00);
        set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
        cycle("raw_gap1", 2'b10, 2'b10, 2'b00);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL %s got a1=%0d a2=%0d sd=%0d cnt=%0d expected a1=%0d a2=%0d sd=%0d cnt=%0d", t, o.a1, o.a2, o.sd, o.cnt, e.a1, e.a2, e.sd, e.cnt); end
        end
    endtask

    task automatic test_load_use();
        outs_t e, o; string t;
        flush();
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
        cycle("lu_lw", 2'b00, 2'b00, 2'b00);
        set_id(1'b1, 5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0b expected=1", stall); end
        bump();
        cycle("lu_bubble", 2'b00, 2'b00, 2'b00);
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL lu_release got=%0b expected=0", stall); end
        cycle("lu_sw", 2'b00, 2'b00, 2'b10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL %s got a1=%0d a2=%0d sd=%0d cnt=%0d expected a1=%0d a2=%0d sd=%0d cnt=%0d", t, o.a1, o.a2, o.sd, o.cnt, e.a1, e.a2, e.sd, e.cnt); end
        end
    endtask

    task automatic test_r0_imm();
        outs_t e, o; string t;
        flush();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        cycle("r0_write", 2'b00, 2'b00, 2'b00);
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        cycle("r0_use", 2'b00, 2'b00, 2'b00);
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
        cycle("imm_prod", 2'b00, 2'b00, 2'b00);
        set_id(1'b1, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
        cycle("imm_rt", 2'b00, 2'b00, 2'b00);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL %s got a1=%0d a2=%0d sd=%0d cnt=%0d expected a1=%0d a2=%0d sd=%0d cnt=%0d", t, o.a1, o.a2, o.sd, o.cnt, e.a1, e.a2, e.sd, e.cnt); end
        end
    endtask

    task automatic test_priority();
        outs_t e, o; string t;
        flush();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);
        cycle("prio_r7a", 2'b00, 2'b00, 2'b00);
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);
        cycle("prio_r7b", 2'b00, 2'b00, 2'b00);
        set_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        cycle("prio_use", 2'b01, 2'b01, 2'b01);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL %s got a1=%0d a2=%0d sd=%0d cnt=%0d expected a1=%0d a2=%0d sd=%0d cnt=%0d", t, o.a1, o.a2, o.sd, o.cnt, e.a1, e.a2, e.sd, e.cnt); end
        end
    endtask

    task automatic test_hold();
        outs_t e, o; string t;
        flush();
        set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0);
        cycle("hold_add_r1", 2'b00, 2'b00, 2'b00);
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1);
        cycle("hold_lw_r8", 2'b01, 2'b00, 2'b00);
        set_id(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (stall !== 1'b0) begin failures++; $display("FAIL hold_stall got=%0b expected=0", stall); end
            cycle("hold_frozen", 2'b01, 2'b00, 2'b00);
        end
        hold = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL hold_release_stall got=%0b expected=1", stall); end
        bump();
        cycle("hold_bubble", 2'b00, 2'b00, 2'b00);
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL hold_once got=%0b expected=0", stall); end
        cycle("hold_consumer", 2'b10, 2'b00, 2'b00);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL %s got a1=%0d a2=%0d sd=%0d cnt=%0d expected a1=%0d a2=%0d sd=%0d cnt=%0d", t, o.a1, o.a2, o.sd, o.cnt, e.a1, e.a2, e.sd, e.cnt); end
        end
    endtask

    task automatic test_back_to_back();
        outs_t e, o; string t;
        flush();
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
        cycle("b2b_lw1", 2'b00, 2'b00, 2'b00);
        set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
        #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL b2b_stall1 got=%0b expected=1", stall); end
        bump();
        cycle("b2b_bubble1", 2'b00, 2'b00, 2'b00);
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL b2b_release1 got=%0b expected=0", stall); end
        cycle("b2b_lw2", 2'b10, 2'b00, 2'b00);
        set_id(1'b1, 5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL b2b_stall2 got=%0b expected=1", stall); end
        bump();
        cycle("b2b_bubble2", 2'b00, 2'b00, 2'b00);
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL b2b_release2 got=%0b expected=0", stall); end
        cycle("b2b_sw", 2'b00, 2'b00, 2'b10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL %s got a1=%0d a2=%0d sd=%0d cnt=%0d expected a1=%0d a2=%0d sd=%0d cnt=%0d", t, o.a1, o.a2, o.sd, o.cnt, e.a1, e.a2, e.sd, e.cnt); end
        end
    endtask

    task automatic test_saturation();
        outs_t e, o; string t;
        flush();
        for (int i = 0; i < 20; i++) begin
            set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
            cycle("sat_lw", 2'b00, 2'b00, 2'b00);
            set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
            bump();
            cycle("sat_bubble", 2'b00, 2'b00, 2'b00);
            cycle("sat_use", 2'b10, 2'b00, 2'b00);
        end
        checks++;
        if (stall_count !== 4'hF) begin failures++; $display("FAIL sat_final got=%0h expected=f", stall_count); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL %s got a1=%0d a2=%0d sd=%0d cnt=%0d expected a1=%0d a2=%0d sd=%0d cnt=%0d", t, o.a1, o.a2, o.sd, o.cnt, e.a1, e.a2, e.sd, e.cnt); end
        end
    endtask

    task automatic test_reset_mid_stall();
        outs_t e, o; string t;
        flush();
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
        cycle("rms_lw", 2'b00, 2'b00, 2'b00);
        set_id(1'b1, 5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL rms_stall got=%0b expected=1", stall); end
        rst = 1'b0;
        exp_cnt = 4'd0;
        cycle("rms_reset", 2'b00, 2'b00, 2'b00);
        rst = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL rms_after got=%0b expected=0", stall); end
        cycle("rms_sw", 2'b00, 2'b00, 2'b00);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL %s got a1=%0d a2=%0d sd=%0d cnt=%0d expected a1=%0d a2=%0d sd=%0d cnt=%0d", t, o.a1, o.a2, o.sd, o.cnt, e.a1, e.a2, e.sd, e.cnt); end
        end
    endtask

    initial begin
        rst = 1'b0;
        hold = 1'b0;
        nop_id();
        #2;
        test_reset();
        test_alu_raw();
        test_load_use();
        test_r0_imm();
        test_priority();
        test_hold();
        test_back_to_back();
        test_saturation();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
